// File: rtl/prng_pkg.sv
// Shared types and defaults for the PRNG request arbiter.
// No logic here; no latency or backpressure of its own.
// Holds the FSM encoding, the operation type and the default sizes.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    typedef enum logic {
        OP_RAND = 1'b0,
        OP_SEED = 1'b1
    } op_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 64;
    localparam int WDOG_W      = 10;

endpackage

// File: rtl/prng_rr_pick.sv
// Round-robin picker: first set request after last_i, wrapping NREQ-1 -> 0.
// Purely combinational, zero latency.
// No backpressure; any_o low means nothing to grant.
module prng_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = IW'((int'(last_i) + k) % NREQ);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/prng_arbiter.sv
// Shares one PRNG among NREQ requesters; optional watchdog via PRNG_ARB_TIMEOUT_EN.
// Latency: req at cycle 0 -> command at 1 -> data_done at k -> rsp_valid at k+1.
// One transaction in flight; requests are held off (no grant) until it completes.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_is_seed,
    input  logic [NREQ*WIDTH-1:0]    seed_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     get_random,
    output logic                     load_seed,
    output logic [WIDTH-1:0]         seed_out,
    input  logic                     data_done,
    input  logic [WIDTH-1:0]         rand_in,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err
);

    localparam int IW = $clog2(NREQ);

    arb_state_t       state_q;
    op_t              op_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    last_q;
    logic [NREQ-1:0]  gnt_q;
    logic             get_random_q;
    logic             load_seed_q;
    logic [WIDTH-1:0] seed_out_q;
    logic             rsp_valid_q;
    logic [IW-1:0]    rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic [NREQ-1:0]  pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] seed_sel;
    logic             wdog_exp;

    prng_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        seed_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                seed_sel = seed_in[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PRNG_ARB_TIMEOUT_EN
    // Counts completed WAIT cycles; expiry is the TIMEOUT-th WAIT cycle.
    logic [WDOG_W-1:0] wdog_q;

    assign wdog_exp = (wdog_q == WDOG_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_q == WAIT && !data_done && !wdog_exp) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign wdog_exp = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_RAND;
            idx_q        <= '0;
            last_q       <= IW'(NREQ - 1);
            gnt_q        <= '0;
            get_random_q <= 1'b0;
            load_seed_q  <= 1'b0;
            seed_out_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= ISSUE;
                        gnt_q   <= pick_gnt;
                        idx_q   <= pick_idx;
                        op_q    <= op_t'(req_is_seed[pick_idx]);
                        if (req_is_seed[pick_idx]) begin
                            load_seed_q <= 1'b1;
                            seed_out_q  <= seed_sel;
                        end else begin
                            get_random_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q      <= WAIT;
                    get_random_q <= 1'b0;
                    load_seed_q  <= 1'b0;
                    seed_out_q   <= '0;
                end
                WAIT: begin
                    // data_done beats a coincident watchdog expiry
                    if (data_done) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= idx_q;
                        rsp_data_q  <= (op_q == OP_RAND) ? rand_in : '0;
                        rsp_err_q   <= 1'b0;
                    end else if (wdog_exp) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= idx_q;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    last_q      <= idx_q;
                    gnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_id_q    <= '0;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign get_random = get_random_q;
    assign load_seed  = load_seed_q;
    assign seed_out   = seed_out_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_prng_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int TMO   = 8;
`ifdef PRNG_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ-1:0]         req_is_seed = '0;
    logic [NREQ*WIDTH-1:0]   seed_in = '0;
    logic [NREQ-1:0]         gnt;
    logic                    get_random;
    logic                    load_seed;
    logic [WIDTH-1:0]        seed_out;
    logic                    data_done = 1'b0;
    logic [WIDTH-1:0]        rand_in = '0;
    logic                    rsp_valid;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [WIDTH-1:0]        rsp_data;
    logic                    rsp_err;

    int n_chk  = 0;
    int n_pass = 0;
    int last_srv = NREQ - 1;

    prng_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_is_seed (req_is_seed),
        .seed_in     (seed_in),
        .gnt         (gnt),
        .get_random  (get_random),
        .load_seed   (load_seed),
        .seed_out    (seed_out),
        .data_done   (data_done),
        .rand_in     (rand_in),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_idle_out(input string tag);
        check(tag, {gnt, get_random, load_seed, rsp_valid}, '0);
    endtask

    // One full transaction. d = WAIT-cycle index on which data_done is raised.
    task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] s, input int d,
                           input logic [WIDTH-1:0] rv, input logic [WIDTH-1:0] sv,
                           output int served);
        int               win;
        int               w;
        bit               done;
        bit               exp_err;
        logic [WIDTH-1:0] exp_data;
        logic [WIDTH-1:0] seeds [NREQ];
        logic [NREQ-1:0]  oh;

        win = rr_winner(r, last_srv);
        oh  = NREQ'(1) << win;
        for (int i = 0; i < NREQ; i++) seeds[i] = (i == win) ? sv : $urandom;
        for (int i = 0; i < NREQ; i++) seed_in[i*WIDTH +: WIDTH] = seeds[i];
        req         = r;
        req_is_seed = s;
        data_done   = 1'b0;
        rand_in     = $urandom;
        tick;
        check("issue_gnt", gnt, oh);
        check("issue_cmd", {get_random, load_seed}, {!s[win], s[win]});
        if (s[win]) check("issue_seed", seed_out, seeds[win]);
        // late input changes and stray data_done must not disturb this transaction
        req         = NREQ'($urandom);
        req_is_seed = NREQ'($urandom);
        seed_in     = {$urandom, $urandom, $urandom, $urandom};
        data_done   = 1'($urandom);
        rand_in     = $urandom;
        tick;
        w        = 0;
        done     = 1'b0;
        exp_err  = 1'b0;
        exp_data = '0;
        while (!done) begin
            check("wait_out", {gnt, get_random, load_seed, rsp_valid}, {oh, 3'b000});
            rand_in   = (w == d) ? rv : $urandom;
            data_done = (w == d);
            if (w == d) begin
                exp_data = s[win] ? '0 : rv;
                exp_err  = 1'b0;
                done     = 1'b1;
            end else if (TMO_EN && w == TMO - 1) begin
                exp_data = '0;
                exp_err  = 1'b1;
                done     = 1'b1;
            end
            tick;
            w++;
            if (!done && w > 64) begin
                check("wait_bound", 1'b0, 1'b1);
                done = 1'b1;
            end
        end
        data_done = 1'($urandom);
        req       = '0;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, win);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_gnt", gnt, oh);
        served = int'(rsp_id);
        tick;
        check_idle_out("post_rsp");
        data_done = 1'b0;
        last_srv  = win;
    endtask

    initial begin
        int served;
        int order [5] = '{0, 1, 2, 3, 0};

        repeat (2) tick;
        check("rst_gnt", gnt, '0);
        check("rst_cmd", {get_random, load_seed, rsp_valid, rsp_err}, '0);
        check("rst_rsp", {rsp_id, rsp_data}, '0);
        rst = 1'b0;
        tick;
        check_idle_out("idle_noreq");

        // all requesting: round-robin from reset
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 4'b0000, $urandom_range(0, 4), $urandom, $urandom, served);
            check("rr_order", served, order[i]);
        end

        // single requester 2, data_done three cycles after get_random
        run_txn(4'b0100, 4'b0000, 2, 32'hDEADBEEF, $urandom, served);

        // seed load from requester 1
        run_txn(4'b0010, 4'b0010, 1, $urandom, 32'h12345678, served);

        // watchdog: no data_done, then data_done exactly on the expiry cycle
        if (TMO_EN) begin
            run_txn(4'b0001, 4'b0000, 100, $urandom, $urandom, served);
            run_txn(4'b1000, 4'b0000, TMO - 1, 32'hCAFEF00D, $urandom, served);
        end

        // reset in the middle of WAIT aborts silently
        req         = 4'b0100;
        req_is_seed = '0;
        tick;
        req = '0;
        repeat (2) tick;
        rst = 1'b1;
        #1;
        check("midrst_out", {gnt, get_random, load_seed, rsp_valid, rsp_err}, '0);
        check("midrst_rsp", {rsp_id, rsp_data, seed_out}, '0);
        tick;
        rst       = 1'b0;
        last_srv  = NREQ - 1;
        data_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("midrst_quiet", rsp_valid, 1'b0);
        end
        data_done = 1'b0;
        run_txn(4'b1001, 4'b0000, 1, $urandom, $urandom, served);
        check("midrst_first", served, 0);

        // randomized traffic with idle gaps
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                req       = '0;
                data_done = 1'($urandom);
                tick;
                check_idle_out("rand_idle");
            end
            data_done = 1'b0;
            run_txn(NREQ'($urandom_range(1, 15)), NREQ'($urandom), $urandom_range(0, 11),
                    $urandom, $urandom, served);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
